// File: rtl/aes_demux_pkg.sv
// Shared types and helpers for the aes128 word demultiplexer.
// Word k of a block sits in the slice starting at slice_lo(k), MSB-first.
package aes_demux_pkg;

    localparam int W_DEF     = 32;
    localparam int WORDS_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } lane_state_t;

    function automatic int slice_lo(input int k,
                                    input int w     = W_DEF,
                                    input int words = WORDS_DEF);
        return w * (words - k - 1);
    endfunction

endpackage

// File: rtl/aes_demux_lane.sv
// One output lane: packs words MSB-first into a block, then holds it until drained.
//   state | meaning
//   FILL  | accepting words, cnt = index of next word
//   FULL  | block complete, blk_valid high, no words accepted
module aes_demux_lane
    import aes_demux_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic               wr_en,
    input  logic [W-1:0]       wr_data,
    output logic               full,
    output logic [W*WORDS-1:0] blk,
    output logic               blk_valid,
    input  logic               blk_ready
);

    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    lane_state_t        state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [W*WORDS-1:0] blk_q, blk_d;

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= FILL;
            cnt_q   <= '0;
            blk_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        blk_d   = blk_q;
        case (state_q)
            FILL: begin
                if (wr_en) begin
                    blk_d[slice_lo(int'(cnt_q), W, WORDS) +: W] = wr_data;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = FULL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            // No same-cycle bypass: a drained lane only reopens on the next edge.
            FULL: begin
                if (blk_ready) state_d = FILL;
            end
        endcase
    end

    assign full      = (state_q == FULL);
    assign blk_valid = (state_q == FULL);
    assign blk       = blk_q;

endmodule

// File: rtl/aes_word_demux21.sv
// 1-to-2 word demultiplexer: S=0 words build OUT1 (plaintext), S=1 words build OUT2 (round key).
// Each lane stalls independently; IN_READY reflects only the lane picked by S.
module aes_word_demux21
    import aes_demux_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               CLK,
    input  logic               RSTB,
    input  logic [W-1:0]       IN,
    input  logic               S,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic [W*WORDS-1:0] OUT1,
    output logic               OUT1_VALID,
    input  logic               OUT1_READY,
    output logic [W*WORDS-1:0] OUT2,
    output logic               OUT2_VALID,
    input  logic               OUT2_READY
);

    logic full1, full2;
    logic wr1, wr2;

    assign IN_READY = S ? !full2 : !full1;

    // IN_VALID gates first so an undriven S while idle cannot reach either lane.
    assign wr1 = IN_VALID & ~S & ~full1;
    assign wr2 = IN_VALID &  S & ~full2;

    aes_demux_lane #(.W(W), .WORDS(WORDS)) u_lane1 (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .wr_en     (wr1),
        .wr_data   (IN),
        .full      (full1),
        .blk       (OUT1),
        .blk_valid (OUT1_VALID),
        .blk_ready (OUT1_READY)
    );

    aes_demux_lane #(.W(W), .WORDS(WORDS)) u_lane2 (
        .CLK       (CLK),
        .RSTB      (RSTB),
        .wr_en     (wr2),
        .wr_data   (IN),
        .full      (full2),
        .blk       (OUT2),
        .blk_valid (OUT2_VALID),
        .blk_ready (OUT2_READY)
    );

endmodule
